// File: rtl/dcpu_pkg.sv
// Shared CPU bus definitions: requester indices and the arbiter state
// encoding used by wb_arbiter and wb_arb_pick.
package dcpu_pkg;

  localparam int NREQ = 3;

  localparam logic [1:0] REQ_FETCH = 2'd0;
  localparam logic [1:0] REQ_LOAD  = 2'd1;
  localparam logic [1:0] REQ_STORE = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_e;

  // One-hot grant to requester index; an empty grant maps to the fetcher.
  function automatic logic [1:0] grant_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b010:  idx = REQ_LOAD;
      3'b100:  idx = REQ_STORE;
      default: idx = REQ_FETCH;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational grant selection for wb_arbiter.
// WB_ARB_ROUND_ROBIN_EN defined: round-robin starting after the last grant.
// WB_ARB_ROUND_ROBIN_EN undefined: fixed priority store > load > fetch.
module wb_arb_pick (
  input  logic [2:0] i_req,
`ifdef WB_ARB_ROUND_ROBIN_EN
  input  logic [1:0] i_last,
`endif
  output logic [2:0] o_grant
);
  import dcpu_pkg::*;

`ifdef WB_ARB_ROUND_ROBIN_EN
  // Rotate the search so it begins with the requester after the last owner.
  always_comb begin
    o_grant = 3'b000;
    case (i_last)
      REQ_FETCH: begin
        if      (i_req[1]) o_grant = 3'b010;
        else if (i_req[2]) o_grant = 3'b100;
        else if (i_req[0]) o_grant = 3'b001;
      end
      REQ_LOAD: begin
        if      (i_req[2]) o_grant = 3'b100;
        else if (i_req[0]) o_grant = 3'b001;
        else if (i_req[1]) o_grant = 3'b010;
      end
      default: begin
        if      (i_req[0]) o_grant = 3'b001;
        else if (i_req[1]) o_grant = 3'b010;
        else if (i_req[2]) o_grant = 3'b100;
      end
    endcase
  end
`else
  // Stores win over loads, loads over instruction fetches.
  always_comb begin
    o_grant = 3'b000;
    if      (i_req[2]) o_grant = 3'b100;
    else if (i_req[1]) o_grant = 3'b010;
    else if (i_req[0]) o_grant = 3'b001;
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Three-requester Wishbone arbiter (fetch / load / store) onto one master
// port. The grant is registered and held for the owner's whole cycle; a
// watchdog aborts transfers the slave never answers.
// Optional feature: WB_ARB_ROUND_ROBIN_EN selects round-robin arbitration,
// otherwise fixed priority store > load > fetch.
module wb_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_f_cyc,
  input  logic [3:0]    i_f_stb,
  input  logic          i_f_we,
  input  logic [AW-1:0] i_f_addr,
  input  logic [DW-1:0] i_f_dat,
  output logic [DW-1:0] o_f_dat,
  output logic          o_f_ack,
  output logic          o_f_err,
  input  logic          i_l_cyc,
  input  logic [3:0]    i_l_stb,
  input  logic          i_l_we,
  input  logic [AW-1:0] i_l_addr,
  input  logic [DW-1:0] i_l_dat,
  output logic [DW-1:0] o_l_dat,
  output logic          o_l_ack,
  output logic          o_l_err,
  input  logic          i_s_cyc,
  input  logic [3:0]    i_s_stb,
  input  logic          i_s_we,
  input  logic [AW-1:0] i_s_addr,
  input  logic [DW-1:0] i_s_dat,
  output logic [DW-1:0] o_s_dat,
  output logic          o_s_ack,
  output logic          o_s_err,
  output logic          o_wb_cyc,
  output logic [3:0]    o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_dat,
  input  logic [DW-1:0] i_wb_dat,
  input  logic          i_wb_ack,
  input  logic          i_wb_err
);
  import dcpu_pkg::*;

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  logic [2:0]    cyc_v;
  logic [3:0]    stb_a  [NREQ];
  logic          we_v   [NREQ];
  logic [AW-1:0] addr_a [NREQ];
  logic [DW-1:0] dat_a  [NREQ];

  assign cyc_v     = {i_s_cyc, i_l_cyc, i_f_cyc};
  assign stb_a[0]  = i_f_stb;
  assign stb_a[1]  = i_l_stb;
  assign stb_a[2]  = i_s_stb;
  assign we_v[0]   = i_f_we;
  assign we_v[1]   = i_l_we;
  assign we_v[2]   = i_s_we;
  assign addr_a[0] = i_f_addr;
  assign addr_a[1] = i_l_addr;
  assign addr_a[2] = i_s_addr;
  assign dat_a[0]  = i_f_dat;
  assign dat_a[1]  = i_l_dat;
  assign dat_a[2]  = i_s_dat;

  arb_state_e      state_q, state_d;
  logic [2:0]      owner_q, owner_d;     // one-hot owner
  logic [WD_W-1:0] wd_q, wd_d;
  logic            abort_new_q, abort_new_d;
  logic [2:0]      grant;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;
`endif

  wb_arb_pick u_pick (
    .i_req   (cyc_v),
`ifdef WB_ARB_ROUND_ROBIN_EN
    .i_last  (ptr_q),
`endif
    .o_grant (grant)
  );

  logic          owner_cyc;
  logic [3:0]    owner_stb;
  logic          owner_we;
  logic [AW-1:0] owner_addr;
  logic [DW-1:0] owner_dat;

  // AND-OR mux of the current owner's request signals.
  always_comb begin
    owner_cyc  = 1'b0;
    owner_stb  = '0;
    owner_we   = 1'b0;
    owner_addr = '0;
    owner_dat  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q[i]) begin
        owner_cyc  = owner_cyc  | cyc_v[i];
        owner_stb  = owner_stb  | stb_a[i];
        owner_we   = owner_we   | we_v[i];
        owner_addr = owner_addr | addr_a[i];
        owner_dat  = owner_dat  | dat_a[i];
      end
    end
  end

  // Next state, owner latch, watchdog count and abort-entry flag.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wd_d        = wd_q;
    abort_new_d = 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (|cyc_v) begin
          state_d = ARB_BUSY;
          owner_d = grant;
          wd_d    = '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
          ptr_d   = grant_to_idx(grant);
`endif
        end
      end
      ARB_BUSY: begin
        if (i_wb_ack || i_wb_err) begin
          wd_d = '0;
        end else if ((owner_stb != 4'h0) && (wd_q != WD_MAX)) begin
          wd_d = wd_q + 1'b1;
        end
        if (!owner_cyc) begin
          state_d = ARB_IDLE;
          owner_d = 3'b000;
        end else if ((TIMEOUT != 0) && (wd_q == WD_MAX)) begin
          state_d     = ARB_ABORT;
          abort_new_d = 1'b1;
        end
      end
      ARB_ABORT: begin
        if (!owner_cyc) begin
          state_d = ARB_IDLE;
          owner_d = 3'b000;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = 3'b000;
      end
    endcase
  end

  // Arbiter state registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= 3'b000;
      wd_q        <= '0;
      abort_new_q <= 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
      ptr_q       <= REQ_FETCH;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wd_q        <= wd_d;
      abort_new_q <= abort_new_d;
`ifdef WB_ARB_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  logic [2:0]    ack_v, err_v;
  logic [DW-1:0] rd_dat;

  // Master port drive and ack/err/data routing back to the requesters.
  always_comb begin
    o_wb_cyc  = 1'b0;
    o_wb_stb  = 4'h0;
    o_wb_we   = 1'b0;
    o_wb_addr = '0;
    o_wb_dat  = '0;
    ack_v     = 3'b000;
    err_v     = 3'b000;
    // Read data only matters while a transfer is in flight; keeping it at
    // zero in IDLE also holds every output low across reset.
    rd_dat    = (state_q == ARB_IDLE) ? '0 : i_wb_dat;
    case (state_q)
      ARB_BUSY: begin
        o_wb_cyc  = owner_cyc;
        o_wb_stb  = owner_stb;
        o_wb_we   = owner_we;
        o_wb_addr = owner_addr;
        o_wb_dat  = owner_dat;
        ack_v     = owner_q & {3{i_wb_ack}};
        err_v     = owner_q & {3{i_wb_err}};
      end
      ARB_ABORT: begin
        err_v = owner_q & {3{abort_new_q}};
      end
      default: begin
      end
    endcase
  end

  assign o_f_dat = rd_dat;
  assign o_l_dat = rd_dat;
  assign o_s_dat = rd_dat;
  assign o_f_ack = ack_v[0];
  assign o_l_ack = ack_v[1];
  assign o_s_ack = ack_v[2];
  assign o_f_err = err_v[0];
  assign o_l_err = err_v[1];
  assign o_s_err = err_v[2];

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: cycle-by-cycle vector table with a
// scoreboard queue of expected outputs. Expected contention order follows
// WB_ARB_ROUND_ROBIN_EN when that macro is defined.
module tb_wb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  localparam logic [31:0] A_F = 32'h0000_0010;
  localparam logic [31:0] A_L = 32'h0000_0100;
  localparam logic [31:0] A_S = 32'h0000_0200;
  localparam logic [31:0] D_F = 32'hF00D_0001;
  localparam logic [31:0] D_L = 32'hF00D_0002;
  localparam logic [31:0] D_S = 32'hF00D_0003;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_cyc, l_cyc, s_cyc;
  logic [3:0]    f_stb, l_stb, s_stb;
  logic [DW-1:0] f_dat_o, l_dat_o, s_dat_o;
  logic          f_ack, l_ack, s_ack, f_err, l_err, s_err;
  logic          wb_cyc, wb_we;
  logic [3:0]    wb_stb;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic          wb_ack, wb_err;

  always #5 clk = ~clk;

  wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_f_cyc(f_cyc), .i_f_stb(f_stb), .i_f_we(1'b0), .i_f_addr(A_F), .i_f_dat(D_F),
    .o_f_dat(f_dat_o), .o_f_ack(f_ack), .o_f_err(f_err),
    .i_l_cyc(l_cyc), .i_l_stb(l_stb), .i_l_we(1'b0), .i_l_addr(A_L), .i_l_dat(D_L),
    .o_l_dat(l_dat_o), .o_l_ack(l_ack), .o_l_err(l_err),
    .i_s_cyc(s_cyc), .i_s_stb(s_stb), .i_s_we(1'b1), .i_s_addr(A_S), .i_s_dat(D_S),
    .o_s_dat(s_dat_o), .o_s_ack(s_ack), .o_s_err(s_err),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
    .o_wb_dat(wb_dat_o), .i_wb_dat(wb_dat_i), .i_wb_ack(wb_ack), .i_wb_err(wb_err)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  cyc;    // {store, load, fetch}
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic        ecyc;
    logic [31:0] eaddr;  // owner address on the master port, 0 when none
    logic [2:0]  eack;
    logic [2:0]  eerr;
    logic [31:0] edat;
  } vec_t;

  vec_t tbl[80];
  int   n = 0;
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void add(input logic r, input logic [2:0] c, input logic a,
                              input logic e, input logic [31:0] d, input logic ec,
                              input logic [31:0] ea, input logic [2:0] eak,
                              input logic [2:0] eer, input logic [31:0] ed);
    tbl[n].rst = r;   tbl[n].cyc = c;    tbl[n].ack = a;    tbl[n].err = e;
    tbl[n].dat = d;   tbl[n].ecyc = ec;  tbl[n].eaddr = ea; tbl[n].eack = eak;
    tbl[n].eerr = eer; tbl[n].edat = ed;
    n++;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst      = v.rst;
    f_cyc    = v.cyc[0];
    l_cyc    = v.cyc[1];
    s_cyc    = v.cyc[2];
    f_stb    = v.cyc[0] ? 4'hF : 4'h0;
    l_stb    = v.cyc[1] ? 4'hF : 4'h0;
    s_stb    = v.cyc[2] ? 4'hF : 4'h0;
    wb_ack   = v.ack;
    wb_err   = v.err;
    wb_dat_i = v.dat;
  endtask

  logic [31:0] addr_of [3];
  int          ord [3];

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t        e;
    vec_t        z;
    logic [2:0]  rem;
    logic [2:0]  oh;
    logic [31:0] xdat;

    addr_of[0] = A_F; addr_of[1] = A_L; addr_of[2] = A_S;
`ifdef WB_ARB_ROUND_ROBIN_EN
    ord[0] = 1; ord[1] = 2; ord[2] = 0;
`else
    ord[0] = 2; ord[1] = 1; ord[2] = 0;
`endif

    z = '{rst: 1'b1, cyc: 3'b000, ack: 1'b0, err: 1'b0, dat: 32'h0,
          ecyc: 1'b0, eaddr: 32'h0, eack: 3'b000, eerr: 3'b000, edat: 32'h0};
    drive(z);
    repeat (2) @(posedge clk);
    #1;

    // Reset held: everything quiet.
    add(1, 3'b000, 0, 0, 32'h0, 0, 32'h0, 3'b000, 3'b000, 32'h0);

    // Single load requester, slave acks on its 2nd cycle.
    add(0, 3'b010, 0, 0, 32'h0,         0, 32'h0, 3'b000, 3'b000, 32'h0);
    add(0, 3'b010, 0, 0, 32'h0,         1, A_L,   3'b000, 3'b000, 32'h0);
    add(0, 3'b010, 1, 0, 32'hDEADBEEF,  1, A_L,   3'b010, 3'b000, 32'hDEADBEEF);
    add(0, 3'b000, 0, 0, 32'h0,         0, A_L,   3'b000, 3'b000, 32'h0);
    add(0, 3'b000, 0, 0, 32'h0,         0, 32'h0, 3'b000, 3'b000, 32'h0);

    // Reset so the round-robin pointer starts at the fetcher.
    add(1, 3'b000, 0, 0, 32'h0, 0, 32'h0, 3'b000, 3'b000, 32'h0);

    // Contention: all three request together.
    rem = 3'b111;
    for (int k = 0; k < 3; k++) begin
      oh   = 3'b001 << ord[k];
      xdat = 32'h1111_0000 + 32'(ord[k]);
      add(0, rem, 0, 0, 32'h0, 0, 32'h0, 3'b000, 3'b000, 32'h0);
      add(0, rem, 1, 0, xdat,  1, addr_of[ord[k]], oh, 3'b000, xdat);
      rem = rem & ~oh;
      add(0, rem, 0, 0, 32'h0, 0, addr_of[ord[k]], 3'b000, 3'b000, 32'h0);
    end
    add(0, 3'b000, 0, 0, 32'h0, 0, 32'h0, 3'b000, 3'b000, 32'h0);

    // Grant lock: fetch does 3 acked beats while store waits.
    add(0, 3'b001, 0, 0, 32'h0, 0, 32'h0, 3'b000, 3'b000, 32'h0);
    for (int k = 0; k < 3; k++)
      add(0, 3'b101, 1, 0, 32'h5A00 + 32'(k), 1, A_F, 3'b001, 3'b000, 32'h5A00 + 32'(k));
    add(0, 3'b100, 0, 0, 32'h0, 0, A_F,   3'b000, 3'b000, 32'h0);
    add(0, 3'b100, 0, 0, 32'h0, 0, 32'h0, 3'b000, 3'b000, 32'h0);
    add(0, 3'b100, 1, 0, 32'h0, 1, A_S,   3'b100, 3'b000, 32'h0);
    add(0, 3'b000, 0, 0, 32'h0, 0, A_S,   3'b000, 3'b000, 32'h0);
    add(0, 3'b000, 0, 0, 32'h0, 0, 32'h0, 3'b000, 3'b000, 32'h0);

    // Bus error while busy is forwarded, not an abort.
    add(0, 3'b010, 0, 0, 32'h0, 0, 32'h0, 3'b000, 3'b000, 32'h0);
    add(0, 3'b010, 0, 1, 32'h0, 1, A_L,   3'b000, 3'b010, 32'h0);
    add(0, 3'b010, 1, 0, 32'h0, 1, A_L,   3'b010, 3'b000, 32'h0);
    add(0, 3'b000, 0, 0, 32'h0, 0, A_L,   3'b000, 3'b000, 32'h0);

    // Watchdog: store holds stb, slave never answers.
    add(0, 3'b100, 0, 0, 32'h0, 0, 32'h0, 3'b000, 3'b000, 32'h0);
    for (int k = 0; k < 5; k++)
      add(0, 3'b100, 0, 0, 32'h0, 1, A_S, 3'b000, 3'b000, 32'h0);
    add(0, 3'b100, 0, 0, 32'h0, 0, 32'h0, 3'b000, 3'b100, 32'h0);
    add(0, 3'b100, 1, 1, 32'h0, 0, 32'h0, 3'b000, 3'b000, 32'h0);
    add(0, 3'b000, 0, 0, 32'h0, 0, 32'h0, 3'b000, 3'b000, 32'h0);
    add(0, 3'b000, 0, 0, 32'h0, 0, 32'h0, 3'b000, 3'b000, 32'h0);

    // Reset mid-transfer; a late ack must not reach the load unit.
    add(0, 3'b010, 0, 0, 32'h0,        0, 32'h0, 3'b000, 3'b000, 32'h0);
    add(1, 3'b010, 0, 0, 32'h0,        1, A_L,   3'b000, 3'b000, 32'h0);
    add(0, 3'b010, 1, 0, 32'h12345678, 0, 32'h0, 3'b000, 3'b000, 32'h0);
    add(0, 3'b000, 0, 0, 32'h0,        0, A_L,   3'b000, 3'b000, 32'h0);
    add(0, 3'b000, 0, 0, 32'h0,        0, 32'h0, 3'b000, 3'b000, 32'h0);

    for (int i = 0; i < n; i++) begin
      drive(tbl[i]);
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk("wb_cyc",  i, {31'h0, wb_cyc}, {31'h0, e.ecyc});
      chk("wb_stb",  i, {28'h0, wb_stb}, e.ecyc ? 32'hF : 32'h0);
      chk("wb_addr", i, wb_addr, e.eaddr);
      chk("wb_we",   i, {31'h0, wb_we}, {31'h0, (e.eaddr == A_S)});
      chk("wb_dat",  i, wb_dat_o, (e.eaddr == A_F) ? D_F : (e.eaddr == A_L) ? D_L :
                                  (e.eaddr == A_S) ? D_S : 32'h0);
      chk("ack",     i, {29'h0, s_ack, l_ack, f_ack}, {29'h0, e.eack});
      chk("err",     i, {29'h0, s_err, l_err, f_err}, {29'h0, e.eerr});
      chk("l_dat",   i, l_dat_o, e.edat);
      chk("f_dat",   i, f_dat_o, e.edat);
      chk("s_dat",   i, s_dat_o, e.edat);
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Three-requester Wishbone arbiter sharing the CPU's single external bus master port between the instruction fetcher, the load unit and the store unit. It replaces the ad-hoc combinational `cyc ? : ` muxing in the CPU top level with a registered grant. A grant is held for the whole owner cycle (`cyc` high). A watchdog aborts transfers the slave never acknowledges.

## Interface

Parameters:
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `TIMEOUT`, default 255: cycles without `ack`/`err` before abort. 0 disables the watchdog.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `i_clk`, in, 1: clock.
  - `i_reset`, in, 1: synchronous reset, active-high.
- Requester ports. The prefix `x` stands for `f` (fetcher, index 0), `l` (load, index 1) and `s` (store, index 2).
  - `i_x_cyc`, in, 1: bus request / cycle.
  - `i_x_stb`, in, 4: byte-lane strobes.
  - `i_x_we`, in, 1: write enable.
  - `i_x_addr`, in, AW: address.
  - `i_x_dat`, in, DW: write data.
  - `o_x_dat`, out, DW: read data (`i_wb_dat` broadcast to all requesters).
  - `o_x_ack`, out, 1: acknowledge, routed to the owner only.
  - `o_x_err`, out, 1: error, routed to the owner only.
- Master port:
  - `o_wb_cyc`, out, 1.
  - `o_wb_stb`, out, 4.
  - `o_wb_we`, out, 1.
  - `o_wb_addr`, out, AW.
  - `o_wb_dat`, out, DW.
  - `i_wb_dat`, in, DW.
  - `i_wb_ack`, in, 1.
  - `i_wb_err`, in, 1.

## Operation

- States:
  - IDLE: no owner. All master outputs are 0.
  - BUSY: owner latched. Master outputs are a combinational pass-through of the owner's inputs. `i_wb_ack` and `i_wb_err` go only to the owner.
  - ABORT: watchdog fired. `o_wb_cyc` and `o_wb_stb` are 0. The owner sees `o_x_err` high for exactly 1 cycle on entry. Bus `ack`/`err` are ignored.
- Transitions:
  - IDLE → BUSY when any `i_x_cyc` is high. The owner is picked by the priority function.
  - BUSY → IDLE when the owner's `i_x_cyc` is low.
  - BUSY → ABORT when the watchdog count reaches `TIMEOUT`.
  - ABORT → IDLE when the owner's `i_x_cyc` is low.
- Non-owner requesters: `ack` and `err` are 0. They wait with `cyc` held.
- Watchdog: the counter clears on every `i_wb_ack` or `i_wb_err`, and on entry to BUSY. It increments each BUSY cycle in which the owner's `stb` is nonzero. The width is `$clog2(TIMEOUT+1)` and it saturates at `TIMEOUT`.
- Owner drops `cyc` in the same cycle `ack` arrives: the ack is still forwarded that cycle, then the arbiter releases.
- Bus error while BUSY: forwarded as `o_x_err`. It is not an abort; the owner decides whether to release.
- Reset in any state:
  - State goes to IDLE, with no owner.
  - The watchdog clears to 0.
  - The round-robin pointer is set to the fetcher.
  - All `o_*` outputs are 0 in the cycle after reset is sampled and while reset is held.

## Timing

- Grant latency: a request sampled in IDLE at cycle N gives `o_wb_cyc` high at N+1.
- Ack/err/data path: combinational, 0 cycles.
- Release: owner `cyc` low at cycle M gives master `cyc` low at M (pass-through) and IDLE at M+1. A waiting requester gets master `cyc` at M+2.
- Abort: count reaches `TIMEOUT` at cycle T. State is ABORT at T+1, with `o_x_err` high and master `cyc` low in T+1.

## Configuration

- `WB_ARB_ROUND_ROBIN_EN`
  - Defined: round-robin arbitration. The search starts at the requester after the last granted one. The pointer updates on every IDLE→BUSY grant.
  - Undefined: fixed priority, store > load > fetch. No pointer register.

## Structure

- Shared package `dcpu_pkg`:
  - requester index constants `REQ_FETCH=0`, `REQ_LOAD=1`, `REQ_STORE=2`;
  - arbiter state encoding (IDLE, BUSY, ABORT).
- One sub-module, `wb_arb_pick`: combinational request vector plus last-grant to one-hot grant. It contains the macro-selected priority logic.

## Test plan

- Single requester:
  - Stimulus: load asserts `cyc`, `stb=4'b1111`, `addr=0x100`; slave acks with `dat=0xDEADBEEF` on its 2nd cycle.
  - Response: `o_wb_cyc` at +1; `o_l_ack` with `0xDEADBEEF`; `o_f_ack` and `o_s_ack` stay 0.
- Contention:
  - Stimulus: fetch, load and store all request in the same cycle.
  - Fixed priority response: grant order store, load, fetch, with one IDLE cycle between owners.
  - Round-robin response (pointer starting at fetch): grant order load, store, fetch.
- Grant lock:
  - Stimulus: fetch owns the bus and issues 3 back-to-back acked beats while store requests.
  - Response: store is not granted until fetch drops `cyc`.
- Watchdog:
  - Stimulus: `TIMEOUT=4`; store owns the bus with `stb` held and no slave ack.
  - Response: `o_s_err` pulses 1 cycle at the 5th cycle after grant; `o_wb_cyc` is 0 from that cycle; IDLE after store drops `cyc`.
- Reset mid-transfer:
  - Stimulus: assert `i_reset` while load is BUSY.
  - Response: next cycle all outputs are 0 and state is IDLE; a late `i_wb_ack` is not forwarded.
